// File: rtl/vector_checker.sv
// Table-driven on-chip self-test: plays stored stimuli into a pipelined block and
// checks its masked response a fixed LATENCY later, keeping error statistics.
module vector_checker #(
  parameter int IN_W     = 17,
  parameter int OUT_W    = 49,
  parameter int DEPTH    = 1024,
  parameter int LATENCY  = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vec_we,
  input  logic [AW-1:0]           vec_waddr,
  input  logic [IN_W+2*OUT_W-1:0] vec_wdata,
  input  logic                    start,
  input  logic [AW:0]             num_vectors,
  input  logic                    stop_on_error,
  output logic [IN_W-1:0]         dut_in,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [31:0]             error_count,
  output logic [AW-1:0]           first_err_idx,
  output logic [OUT_W-1:0]        first_err_got
);
  localparam int WW = IN_W + 2*OUT_W;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  logic [WW-1:0]    mem [DEPTH];
  logic [WW-1:0]    rd_word;
  logic [AW-1:0]    rd_addr;
  logic [1:0]       state;
  logic [AW:0]      issue_idx;
  logic [AW:0]      issue_next;
  logic [AW:0]      n_reg;
  logic [AW:0]      n_last;
  logic [AW:0]      n_clamped;
  logic             stop_reg;
  logic             idle_like;
  logic             wr_en;
  logic             issuing;
  logic             issue_go;
  logic             last_issue;
  logic             cmp_valid;
  logic             mismatch;
  logic             stop_hit;
  logic             last_cmp;

  logic [OUT_W-1:0]   pipe_exp  [LATENCY];
  logic [OUT_W-1:0]   pipe_mask [LATENCY];
  logic [AW-1:0]      pipe_idx  [LATENCY];
  logic [LATENCY-1:0] pipe_valid;

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign wr_en      = vec_we && idle_like;
  assign issue_next = issue_idx + ONE;
  assign n_last     = n_reg - ONE;
  assign n_clamped  = (num_vectors > DEPTH_V) ? DEPTH_V : num_vectors;

  // Read one entry ahead: address 0 is fetched on the start edge, so a write
  // landing on that same edge to address 0 is not seen by this run.
  assign rd_addr    = (state == RUN) ? issue_next[AW-1:0] : '0;

  assign issuing    = (state == RUN) && (issue_idx < n_reg);
  assign last_issue = issuing && (issue_idx == n_last);
  assign cmp_valid  = pipe_valid[LATENCY-1];
  assign mismatch   = cmp_valid &&
                      (|((dut_out ^ pipe_exp[LATENCY-1]) & pipe_mask[LATENCY-1]));
  assign stop_hit   = mismatch && stop_reg;
  assign issue_go   = issuing && !stop_hit;
  assign last_cmp   = cmp_valid && ({1'b0, pipe_idx[LATENCY-1]} == n_last);

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (error_count == '0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[vec_waddr] <= vec_wdata;
    end
    rd_word <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      issue_idx     <= '0;
      n_reg         <= '0;
      stop_reg      <= 1'b0;
      dut_in        <= '0;
      error_count   <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      pipe_valid    <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_exp[i]  <= '0;
        pipe_mask[i] <= '0;
        pipe_idx[i]  <= '0;
      end
    end else begin
      for (int i = LATENCY-1; i > 0; i--) begin
        pipe_exp[i]   <= pipe_exp[i-1];
        pipe_mask[i]  <= pipe_mask[i-1];
        pipe_idx[i]   <= pipe_idx[i-1];
        pipe_valid[i] <= pipe_valid[i-1];
      end
      pipe_exp[0]   <= rd_word[2*OUT_W-1 -: OUT_W];
      pipe_mask[0]  <= rd_word[OUT_W-1:0];
      pipe_idx[0]   <= issue_idx[AW-1:0];
      pipe_valid[0] <= issue_go;

      if (issue_go) begin
        dut_in    <= rd_word[WW-1 -: IN_W];
        issue_idx <= issue_next;
      end

      if (mismatch) begin
        if (error_count == '0) begin
          first_err_idx <= pipe_idx[LATENCY-1];
          first_err_got <= dut_out;
        end
        if (error_count != '1) begin
          error_count <= error_count + 32'd1;
        end
      end

      // Halting on an error also discards everything still in flight.
      if (stop_hit) begin
        pipe_valid <= '0;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            issue_idx     <= '0;
            n_reg         <= n_clamped;
            stop_reg      <= stop_on_error;
            error_count   <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
          end
        end
        RUN: begin
          if (stop_hit || (n_reg == '0)) begin
            state <= DONE;
          end else if (last_issue) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (stop_hit || last_cmp) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
